// File: rtl/capture_buffer.sv
// Circular pre/post-trigger sample capture memory; define CAPTURE_BUFFER_OUTREG_EN for a registered read output.
// Latency: writes on the din_valid edge; reads take 1 cycle, or 2 with CAPTURE_BUFFER_OUTREG_EN.
// Backpressure: none; the sample stream is never stalled, and reads outside DONE are dropped.
module capture_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  trig,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  localparam logic [ADDR_WIDTH-1:0] max_len = '1;
  localparam logic [ADDR_WIDTH-1:0] one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {st_idle, st_pre, st_armed, st_post, st_done} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0]   wr_ptr, fill, post, pre_len;
  logic [ADDR_WIDTH-1:0]   arm_len, post_init, rd_ptr;
  logic                    we, start, trig_hit, rd_fire;
  logic                    rd_vld_q;
  logic [DATA_WIDTH-1:0]   rd_dat_q;

  assign arm_len   = (pretrig_len >= max_len) ? max_len : pretrig_len;
  assign post_init = max_len - pre_len;

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    start     = 1'b0;
    trig_hit  = 1'b0;
    case (state)
      st_idle, st_done: begin
        if (arm) begin
          start     = 1'b1;
          state_nxt = (arm_len == '0) ? st_armed : st_pre;
        end
      end
      st_pre: begin
        if (din_valid) begin
          we = 1'b1;
          if (fill + one == pre_len) state_nxt = st_armed;
        end
      end
      st_armed: begin
        if (din_valid) begin
          we = 1'b1;
          if (trig) begin
            trig_hit  = 1'b1;
            state_nxt = (post_init == '0) ? st_done : st_post;
          end
        end
      end
      st_post: begin
        if (din_valid) begin
          we = 1'b1;
          if (post == one) state_nxt = st_done;
        end
      end
      default: state_nxt = st_idle;
    endcase
    // abort wins over everything, including a concurrent arm or sample
    if (abort) begin
      state_nxt = st_idle;
      we        = 1'b0;
      start     = 1'b0;
      trig_hit  = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nxt;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      fill      <= '0;
      post      <= '0;
      pre_len   <= '0;
      trig_addr <= '0;
    end else if (start) begin
      wr_ptr  <= '0;
      fill    <= '0;
      pre_len <= arm_len;
    end else if (we) begin
      wr_ptr <= wr_ptr + one;
      if (state == st_pre) fill <= fill + one;
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        post      <= post_init;
      end else if (state == st_post) begin
        post <= post - one;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (we) mem[wr_ptr] <= din;
  end

  assign busy = (state == st_pre) || (state == st_armed) || (state == st_post);
  assign done = (state == st_done);

  // in DONE wr_ptr has landed on the oldest sample, so it doubles as the read base
  assign rd_fire = rd_en && (state == st_done) && !abort;
  assign rd_ptr  = wr_ptr + rd_addr;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_vld_q <= rd_fire;
      if (rd_fire) rd_dat_q <= mem[rd_ptr];
    end
  end

`ifdef CAPTURE_BUFFER_OUTREG_EN
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= rd_vld_q;
      if (rd_vld_q) dout <= rd_dat_q;
    end
  end
`else
  assign dout_valid = rd_vld_q;
  assign dout       = rd_dat_q;
`endif

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer with a sample-history model checked every cycle.
module tb_capture_buffer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef CAPTURE_BUFFER_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clka, rst_n, arm, abort, din_valid, trig, busy, done, rd_en, dout_valid;
  logic [AW-1:0] pretrig_len, trig_addr, rd_addr;
  logic [DW-1:0] din, dout;

  capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka(clka), .rst_n(rst_n), .arm(arm), .abort(abort), .pretrig_len(pretrig_len),
    .din(din), .din_valid(din_valid), .trig(trig), .busy(busy), .done(done),
    .trig_addr(trig_addr), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout),
    .dout_valid(dout_valid)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of the last DEPTH samples written since arm, plus trigger bookkeeping.
  bit            m_busy, m_done, m_dv, p1_v, fire;
  logic [DW-1:0] m_dout, p1_d, rdat;
  int            m_trig_addr, m_nwr, m_tidx, m_len, idx;
  logic [DW-1:0] samples[$];

  always @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dv = 0; p1_v = 0; p1_d = '0; m_dout = '0;
      m_trig_addr = 0; m_nwr = 0; m_tidx = -1; m_len = 0;
      samples.delete();
    end else begin
      fire = m_done && rd_en && !abort;
      rdat = fire ? samples[rd_addr] : '0;
`ifdef CAPTURE_BUFFER_OUTREG_EN
      m_dv = p1_v;
      if (p1_v) m_dout = p1_d;
      p1_v = fire;
      if (fire) p1_d = rdat;
`else
      m_dv = fire;
      if (fire) m_dout = rdat;
`endif
      if (abort) begin
        m_busy = 0; m_done = 0;
      end else if (arm && !m_busy) begin
        m_busy = 1; m_done = 0; m_nwr = 0; m_tidx = -1;
        m_len = (int'(pretrig_len) >= DEPTH - 1) ? DEPTH - 1 : int'(pretrig_len);
        samples.delete();
      end else if (m_busy && din_valid) begin
        idx = m_nwr;
        samples.push_back(din);
        if (samples.size() > DEPTH) void'(samples.pop_front());
        if (m_tidx < 0 && idx >= m_len && trig) begin
          m_tidx = idx;
          m_trig_addr = idx % DEPTH;
        end
        m_nwr++;
        if (m_tidx >= 0 && (m_nwr - m_tidx) == DEPTH - m_len) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  end

  always @(negedge clka) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("dout_valid", 32'(dout_valid), 32'(m_dv));
      chk("dout", 32'(dout), 32'(m_dout));
      chk("trig_addr", 32'(trig_addr), 32'(m_trig_addr));
    end
  end

  task automatic arm_pulse(input int plen);
    pretrig_len = plen[AW-1:0];
    arm = 1'b1;
    @(negedge clka);
    arm = 1'b0;
  endtask

  // Streams din = 0,1,2,... until the DUT reports done, a 3-cycle hole before sample gap_at.
  task automatic stream(input int trig_at, input int early_n, input int gap_at,
                        input int max_samples, output int cycles);
    int v;
    int gap_left;
    v = 0; cycles = 0; gap_left = 3;
    while (!done && cycles < 200 && v < max_samples) begin
      if (v == gap_at && gap_left > 0) begin
        din_valid = 1'b0; trig = 1'b0; gap_left--;
      end else begin
        din = v[DW-1:0]; din_valid = 1'b1;
        trig = (v < early_n) || (v == trig_at);
        v++;
      end
      @(negedge clka);
      cycles++;
    end
    din_valid = 1'b0; trig = 1'b0;
    if (v < max_samples) chk("capture_done", 32'(done), 1);
  endtask

  task automatic read_one(input int k, input int exp, input string name);
    rd_en = 1'b1; rd_addr = k[AW-1:0];
    @(negedge clka);
    rd_en = 1'b0;
    repeat (LAT - 1) @(negedge clka);
    chk({name, "_valid"}, 32'(dout_valid), 1);
    chk(name, 32'(dout), 32'(exp));
  endtask

  task automatic read_all();
    for (int k = 0; k < DEPTH; k++) begin
      rd_en = 1'b1; rd_addr = k[AW-1:0];
      @(negedge clka);
    end
    rd_en = 1'b0;
    repeat (3) @(negedge clka);
  endtask

  int cyc;

  initial begin
    rst_n = 0; arm = 0; abort = 0; pretrig_len = '0; din = '0;
    din_valid = 0; trig = 0; rd_en = 0; rd_addr = '0;
    repeat (2) @(negedge clka);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    #2 rst_n = 1;
    @(negedge clka);

    // reset asserted while armed and streaming
    arm_pulse(4);
    stream(100, 0, -1, 10, cyc);
    #2 rst_n = 0;
    #1 chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    repeat (2) @(negedge clka);
    #2 rst_n = 1;
    @(negedge clka);

    // nominal
    arm_pulse(4);
    stream(20, 0, -1, 1000, cyc);
    chk("nom_cycles", 32'(cyc), 32);
    chk("nom_trig_addr", 32'(trig_addr), 4);
    read_one(0, 16, "nom_rd0");
    read_all();
    chk("nom_rd_last", 32'(dout), 31);

    // early triggers on samples 0..3 ignored, accepted at 6
    arm_pulse(4);
    stream(6, 4, -1, 1000, cyc);
    chk("early_cycles", 32'(cyc), 18);
    chk("early_trig_addr", 32'(trig_addr), 6);
    read_one(0, 2, "early_rd0");
    read_all();
    chk("early_rd_last", 32'(dout), 17);

    // zero pre-trigger
    arm_pulse(0);
    stream(0, 0, -1, 1000, cyc);
    chk("zero_cycles", 32'(cyc), 16);
    chk("zero_trig_addr", 32'(trig_addr), 0);
    read_one(0, 0, "zero_rd0");
    read_all();
    chk("zero_rd_last", 32'(dout), 15);

    // stream gap during POST
    arm_pulse(4);
    stream(20, 0, 24, 1000, cyc);
    chk("gap_cycles", 32'(cyc), 35);
    chk("gap_trig_addr", 32'(trig_addr), 4);
    read_one(5, 21, "gap_rd5");
    read_all();
    chk("gap_rd_last", 32'(dout), 31);

    // clamped pre-trigger: done on the trigger sample itself
    arm_pulse(15);
    stream(20, 0, -1, 1000, cyc);
    chk("clamp_cycles", 32'(cyc), 21);
    chk("clamp_trig_addr", 32'(trig_addr), 4);
    read_one(0, 5, "clamp_rd0");
    read_one(15, 20, "clamp_rd15");

    // abort during POST
    arm_pulse(4);
    stream(20, 0, -1, 25, cyc);
    chk("pre_abort_busy", 32'(busy), 1);
    abort = 1'b1;
    @(negedge clka);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    rd_en = 1'b1; rd_addr = '0;
    @(negedge clka);
    rd_en = 1'b0;
    repeat (LAT - 1) @(negedge clka);
    chk("abort_rd_valid", 32'(dout_valid), 0);

    // arm and abort together
    arm = 1'b1; abort = 1'b1; pretrig_len = 4'd4;
    @(negedge clka);
    arm = 1'b0; abort = 1'b0;
    chk("armabort_busy", 32'(busy), 0);
    repeat (2) @(negedge clka);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
